// File: rtl/shift_seq_ctrl.sv
// Accept-compute-shift-deliver sequencer: captures an operand, asks an external
// datapath for a shift amount, right-shifts by up to STEP bits per cycle, then hands off.
module shift_seq_ctrl #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [31:0] istream_msg,
    output logic [31:0] calc_msg,
    input  logic [5:0]  calc_max,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [31:0] ostream_msg,
    output logic [5:0]  ostream_shamt,
    output logic        busy
);

    // remain_reg never exceeds 31, so a larger STEP behaves exactly like 31.
    localparam logic [5:0] STEP_CAP = (STEP > 31) ? 6'd31 : 6'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SHIFT,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] work_reg, work_next;
    logic [5:0]  shamt_reg, shamt_next;
    logic [5:0]  remain_reg, remain_next;
    logic [5:0]  clamp_amt;
    logic [5:0]  step_amt;

    assign clamp_amt = calc_max[5] ? 6'd31 : calc_max;
    assign step_amt  = (remain_reg < STEP_CAP) ? remain_reg : STEP_CAP;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            data_reg   <= 32'd0;
            work_reg   <= 32'd0;
            shamt_reg  <= 6'd0;
            remain_reg <= 6'd0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            work_reg   <= work_next;
            shamt_reg  <= shamt_next;
            remain_reg <= remain_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        work_next   = work_reg;
        shamt_next  = shamt_reg;
        remain_next = remain_reg;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        busy        = 1'b1;

        case (state_reg)
            IDLE: begin
                istream_rdy = 1'b1;
                busy        = 1'b0;
                if (istream_val) begin
                    // Shifting works on a private copy so calc_msg stays put.
                    data_next  = istream_msg;
                    work_next  = istream_msg;
                    state_next = CALC;
                end
            end
            CALC: begin
                shamt_next  = clamp_amt;
                remain_next = clamp_amt;
                state_next  = (clamp_amt == 6'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                work_next   = work_reg >> step_amt;
                remain_next = remain_reg - step_amt;
                if (remain_reg == step_amt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign calc_msg      = data_reg;
    assign ostream_msg   = work_reg;
    assign ostream_shamt = shamt_reg;

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 4, maximum bit positions shifted per cycle; legal range 1..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port istream_val  input  1  input message valid.
REQ-005 SHALL have port istream_rdy  output  1  block ready to accept input.
REQ-006 SHALL have port istream_msg  input  32  operand to be shifted.
REQ-007 SHALL have port calc_msg  output  32  operand presented to the external shift-amount datapath.
REQ-008 SHALL have port calc_max  input  6  shift amount returned by the datapath, combinational from calc_msg.
REQ-009 SHALL have port ostream_val  output  1  result valid.
REQ-010 SHALL have port ostream_rdy  input  1  consumer ready.
REQ-011 SHALL have port ostream_msg  output  32  shifted result.
REQ-012 SHALL have port ostream_shamt  output  6  total shift applied.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, SHIFT, DONE.
REQ-015 IDLE: istream_rdy=1; on istream_val&istream_rdy, SHALL register istream_msg into data_reg, go to CALC.
REQ-016 calc_msg SHALL equal data_reg as captured at acceptance, held constant until return to IDLE; no combinational path from istream_msg.
REQ-017 CALC (exactly one cycle): SHALL sample calc_max into shamt_reg and remain_reg, clamped to 31 if calc_max>31.
REQ-018 CALC -> DONE if clamped value is 0; else CALC -> SHIFT.
REQ-019 SHIFT: each cycle, SHALL logically right-shift work_reg by min(STEP, remain_reg) (zero fill) and decrement remain_reg by the same amount.
REQ-020 SHIFT -> DONE in the cycle remain_reg reaches 0; SHIFT SHALL last exactly ceil(shamt/STEP) cycles.
REQ-021 work_reg SHALL be a copy of data_reg, so calc_msg is not disturbed by shifting.
REQ-022 DONE: ostream_val=1; ostream_msg=work_reg; ostream_shamt=shamt_reg; all held stable until ostream_rdy=1.
REQ-023 DONE with ostream_rdy=1 SHALL go to IDLE; no new input is accepted in that same cycle.
REQ-024 istream_rdy SHALL be 0 in CALC, SHIFT and DONE; istream_val there SHALL be ignored.
REQ-025 Latency: input accepted in cycle T gives ostream_val first high in cycle T+2+ceil(shamt/STEP).
REQ-026 Final ostream_msg SHALL equal original istream_msg >> shamt for every STEP.
REQ-027 ostream_val SHALL never be asserted in the same cycle as istream_rdy.

Reset
REQ-028 reset_n=0 SHALL immediately, regardless of clk, force: state=IDLE; data_reg, work_reg, shamt_reg, remain_reg = 0.
REQ-029 Reset outputs: istream_rdy=1, ostream_val=0, busy=0, ostream_msg=0, ostream_shamt=0, calc_msg=0.
REQ-030 Reset in any state SHALL abort the in-flight transaction; no output is produced for it.
REQ-031 First acceptance after reset deassertion SHALL be possible on the first rising edge with reset_n=1.

Verification
REQ-032 STEP=4; accept 0xF0000000 in cycle 0 with calc_max=4 -> CALC cycle 1, SHIFT cycle 2, ostream_val cycle 3 with msg 0x0F000000, shamt 4.
REQ-033 STEP=4; accept 0x12345678 with calc_max=0 -> ostream_val cycle 2, msg 0x12345678, shamt 0, SHIFT never entered.
REQ-034 STEP=4; accept 0x80000000 with calc_max=31 -> 8 SHIFT cycles (last shifts 3), ostream_val cycle 10, msg 0x00000001, shamt 31.
REQ-035 calc_max=40 with msg 0xFFFFFFFF -> clamped; ostream_msg 0x00000001, shamt 31.
REQ-036 Hold ostream_rdy=0 for 5 cycles in DONE -> ostream_val, msg, shamt stable, istream_rdy=0; ostream_rdy=1 -> IDLE next cycle, istream_rdy=1.
REQ-037 Assert reset_n=0 mid-SHIFT, between clock edges -> outputs take reset values before the next edge; later transaction 0x00000100, calc_max=8 -> ostream_msg 0x00000001.
